bch_error_locator: RTL

- Decoding stage that sits directly after syndrome computation in the BCH(15,7), t = 2 path.
- Accepts the four syndromes S1..S4 over GF(2^4), primitive polynomial x^4+x+1.
- Runs Berlekamp–Massey to find the error-locator polynomial, then a serial Chien search to locate the error bits.
- Returns a 15-bit error mask that the correction step XORs onto the received word.

---
 rtl/bch_error_locator_if.sv | 41 ++++
 rtl/bch_error_locator.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_error_locator_if.sv
// ---------------------------------------------------------------------------
// bch_error_locator_if
//   Handshake bundle between the syndrome stage, the BCH(15,7) t=2 error
//   locator and the correction stage.
//
//   Syndrome channel (producer -> locator):
//     in_valid           syndrome set valid
//     in_ready           locator can accept a syndrome set
//     in_s1..in_s4       syndromes S1..S4, GF(16) polynomial basis, bit0 = a^0
//   Result channel (locator -> consumer):
//     out_valid          result valid
//     out_ready          consumer accepts result
//     out_err_mask       bit i set = received bit i is in error
//     out_err_count      number of Chien roots found (0..2)
//     out_uncorrectable  decoding failure flag
//
//   Modports: slave = the locator, master = the environment driving it.
// ---------------------------------------------------------------------------
interface bch_error_locator_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_s1;
  logic [3:0]  in_s2;
  logic [3:0]  in_s3;
  logic [3:0]  in_s4;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_err_mask;
  logic [1:0]  out_err_count;
  logic        out_uncorrectable;

  modport slave (
    input  in_valid, in_s1, in_s2, in_s3, in_s4, out_ready,
    output in_ready, out_valid, out_err_mask, out_err_count, out_uncorrectable
  );

  modport master (
    output in_valid, in_s1, in_s2, in_s3, in_s4, out_ready,
    input  in_ready, out_valid, out_err_mask, out_err_count, out_uncorrectable
  );
endinterface

// File: rtl/bch_error_locator.sv
// ---------------------------------------------------------------------------
// bch_error_locator
//   Error-locator stage of a BCH(15,7), t = 2 decoder over GF(2^4)
//   (primitive polynomial x^4 + x + 1). Takes the syndromes S1..S4, runs four
//   Berlekamp-Massey iterations (one per cycle) to build
//   sigma(x) = 1 + s1*x + s2*x^2, then a serial Chien search over the 15 bit
//   positions (one per cycle) and presents a 15-bit error mask.
//
//   Latency is fixed: accept on edge 0, BM on edges 1-4, Chien evaluation on
//   edges 5-19, results registered and out_valid raised on edge 20.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-low reset
//     bus   bch_error_locator_if.slave (syndrome in / result out handshakes)
//
//   Build option:
//     BCH_ROOT_CHECK_EN  when defined, a root count that disagrees with the
//                        locator degree L also flags the word uncorrectable
//                        and forces mask/count to zero. When undefined, only
//                        L > 2 flags failure and the Chien result is reported
//                        as found.
// ---------------------------------------------------------------------------
module bch_error_locator (
  input  logic                    clk,
  input  logic                    rst,
  bch_error_locator_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BM    = 2'd1,
    CHIEN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // a^-1 and a^-2: Chien step multipliers (a^14 and a^13)
  localparam logic [3:0] ALPHA_INV1 = 4'h9;
  localparam logic [3:0] ALPHA_INV2 = 4'hD;

  // -------------------------------------------------------------------------
  // GF(16) arithmetic
  // -------------------------------------------------------------------------
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] prod;
    logic [3:0] acc;
    prod = 4'h0;
    acc  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) prod = prod ^ acc;
      // acc * a: shift up and fold x^4 back as x + 1
      acc = {acc[2:0], 1'b0} ^ (acc[3] ? 4'b0011 : 4'b0000);
    end
    return prod;
  endfunction

  // inv(a^k) = a^(15-k); zero maps to zero (only used when d != 0)
  function automatic logic [3:0] gf_inv(input logic [3:0] a);
    logic [3:0] r;
    case (a)
      4'h1:    r = 4'h1;
      4'h2:    r = 4'h9;
      4'h3:    r = 4'hE;
      4'h4:    r = 4'hD;
      4'h5:    r = 4'hB;
      4'h6:    r = 4'h7;
      4'h7:    r = 4'h6;
      4'h8:    r = 4'hF;
      4'h9:    r = 4'h2;
      4'hA:    r = 4'hC;
      4'hB:    r = 4'h5;
      4'hC:    r = 4'hA;
      4'hD:    r = 4'h4;
      4'hE:    r = 4'h3;
      4'hF:    r = 4'h8;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t           state_q, state_d;

  logic [3:0][3:0]  syn_q;      // syn_q[j] holds S(j+1)
  logic [3:0]       sig1_q, sig2_q;
  logic [3:0][3:0]  b_q;        // correction term B(x), b_q[j] = coeff of x^j
  logic [1:0]       len_q;      // locator length L
  logic             fail_q;     // L exceeded 2 at some iteration
  logic [1:0]       k_q;        // BM iteration

  logic [3:0]       r1_q, r2_q; // s1*a^-i, s2*a^-2i
  logic [3:0]       idx_q;      // Chien position; 15 = search finished
  logic [14:0]      mask_q;
  logic [1:0]       cnt_q;      // saturates at 3

  logic [14:0]      res_mask_q;
  logic [1:0]       res_cnt_q;
  logic             res_unc_q;

  // -------------------------------------------------------------------------
  // Berlekamp-Massey iteration (combinational part)
  // -------------------------------------------------------------------------
  logic [3:0]       syn_k1, syn_k0, syn_km1;
  logic [3:0]       disc, disc_inv;
  logic [3:0]       sig1_n, sig2_n;
  logic [3:0][3:0]  b_n;
  logic [1:0]       len_n;
  logic             fail_n;
  logic [2:0]       len_new;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    syn_k1  = syn_q[k_q];
    syn_k0  = (k_q >= 2'd1) ? syn_q[k_q - 2'd1] : 4'h0;
    syn_km1 = (k_q >= 2'd2) ? syn_q[k_q - 2'd2] : 4'h0;

    // discrepancy d = S(k+1) + sum_{i=1..L} sigma_i * S(k+1-i)
    disc = syn_k1;
    if (len_q >= 2'd1) disc = disc ^ gf_mul(sig1_q, syn_k0);
    if (len_q >= 2'd2) disc = disc ^ gf_mul(sig2_q, syn_km1);
    disc_inv = gf_inv(disc);

    sig1_n  = sig1_q;
    sig2_n  = sig2_q;
    b_n     = {b_q[2:0], 4'h0};           // default B <- x*B
    len_n   = len_q;
    fail_n  = fail_q;
    len_new = {1'b0, k_q} + 3'd1 - {1'b0, len_q};

    if (disc != 4'h0) begin
      // T = sigma + d*x*B; the x^3 term is dropped (t = 2)
      sig1_n = sig1_q ^ gf_mul(disc, b_q[0]);
      sig2_n = sig2_q ^ gf_mul(disc, b_q[1]);
      if ({len_q, 1'b0} <= {1'b0, k_q}) begin
        len_n = len_new[1:0];
        if (len_new > 3'd2) fail_n = 1'b1;
        b_n = {4'h0, gf_mul(disc_inv, sig2_q), gf_mul(disc_inv, sig1_q), disc_inv};
      end
    end
  end

  // -------------------------------------------------------------------------
  // Chien evaluation and result selection
  // -------------------------------------------------------------------------
  logic        root;
  logic        unc_c;
  logic [14:0] mask_c;
  logic [1:0]  cnt_c;

  assign root = ((4'h1 ^ r1_q ^ r2_q) == 4'h0);

`ifdef BCH_ROOT_CHECK_EN
  assign unc_c  = fail_q | (cnt_q != len_q);
  assign mask_c = unc_c ? 15'h0 : mask_q;
  assign cnt_c  = unc_c ? 2'd0  : cnt_q;
`else
  assign unc_c  = fail_q;
  assign mask_c = mask_q;
  assign cnt_c  = cnt_q;
`endif

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = BM;
      end
      BM:    if (k_q == 2'd3) state_d = CHIEN;
      CHIEN: if (idx_q == 4'd15) state_d = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  // NOTE: the syndrome and working registers are reset along with the control
  // state so a reset in the middle of a decode leaves nothing half-computed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syn_q      <= '0;
      sig1_q     <= 4'h0;
      sig2_q     <= 4'h0;
      b_q        <= '0;
      len_q      <= 2'd0;
      fail_q     <= 1'b0;
      k_q        <= 2'd0;
      r1_q       <= 4'h0;
      r2_q       <= 4'h0;
      idx_q      <= 4'd0;
      mask_q     <= 15'h0;
      cnt_q      <= 2'd0;
      res_mask_q <= 15'h0;
      res_cnt_q  <= 2'd0;
      res_unc_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            syn_q  <= {bus.in_s4, bus.in_s3, bus.in_s2, bus.in_s1};
            sig1_q <= 4'h0;
            sig2_q <= 4'h0;
            b_q    <= {4'h0, 4'h0, 4'h0, 4'h1};
            len_q  <= 2'd0;
            fail_q <= 1'b0;
            k_q    <= 2'd0;
          end
        end
        BM: begin
          sig1_q <= sig1_n;
          sig2_q <= sig2_n;
          b_q    <= b_n;
          len_q  <= len_n;
          fail_q <= fail_n;
          k_q    <= k_q + 2'd1;
          if (k_q == 2'd3) begin
            // seed the Chien registers with the final locator directly
            r1_q   <= sig1_n;
            r2_q   <= sig2_n;
            idx_q  <= 4'd0;
            mask_q <= 15'h0;
            cnt_q  <= 2'd0;
          end
        end
        CHIEN: begin
          if (idx_q != 4'd15) begin
            if (root) begin
              mask_q <= mask_q | (15'd1 << idx_q);
              if (cnt_q != 2'd3) cnt_q <= cnt_q + 2'd1;
            end
            r1_q  <= gf_mul(r1_q, ALPHA_INV1);
            r2_q  <= gf_mul(r2_q, ALPHA_INV2);
            idx_q <= idx_q + 4'd1;
          end else begin
            // results change only here, on entry to DONE
            res_mask_q <= mask_c;
            res_cnt_q  <= cnt_c;
            res_unc_q  <= unc_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_err_mask      = res_mask_q;
  assign bus.out_err_count     = res_cnt_q;
  assign bus.out_uncorrectable = res_unc_q;

endmodule
